// File: rtl/lifo.sv
// lifo: registered-output stack with push/pop bypass; define LIFO_ERR_FLAG_EN to add the err output
module lifo #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  val,
`ifdef LIFO_ERR_FLAG_EN
    output logic                  err,
`endif
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  val_q, val_d;
    logic                  push, pop, byp;
    logic [AW-1:0]         top;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign dataout = dout_q;
    assign val     = val_q;

    // decode the request and compute next count, data and valid
    always_comb begin
        byp     = read & write;
        push    = write & ~read & ~full;
        pop     = read & ~write & (count_q != '0);
        top     = count_q[AW-1:0] - AW'(1);
        count_d = push ? count_q + (AW+1)'(1) : pop ? count_q - (AW+1)'(1) : count_q;
        dout_d  = byp ? datain : pop ? mem_q[top] : dout_q;
        val_d   = byp | pop;
    end

    // storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[count_q[AW-1:0]] <= datain;
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dout_q  <= '0;
            val_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            val_q   <= val_d;
        end
    end

`ifdef LIFO_ERR_FLAG_EN
    logic err_q;
    assign err = err_q;

    // flag a push while full or a pop while empty for one cycle
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= (write & ~read & full) | (read & ~write & (count_q == '0));
    end
`endif
endmodule

// File: tb/tb_lifo.sv
// tb_lifo: directed and randomized checks of lifo against a queue-based stack model
module tb_lifo;
    localparam int DW = 10;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, write, read;
    logic [DW-1:0] datain, dataout;
    logic          val, full;
`ifdef LIFO_ERR_FLAG_EN
    logic          err;
`endif

    int n_assert = 0;
    int n_fail = 0;

    logic [DW-1:0] stk[$];
    logic [DW-1:0] exp_dout;
    logic          exp_val, exp_err;

    lifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .write(write), .datain(datain), .read(read),
        .dataout(dataout), .val(val),
`ifdef LIFO_ERR_FLAG_EN
        .err(err),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rs, input logic w, input logic r, input logic [DW-1:0] d);
        reset = rs; write = w; read = r; datain = d;
        @(posedge clk);
        exp_err = 1'b0;
        if (rs) begin
            stk.delete(); exp_dout = '0; exp_val = 1'b0;
        end else if (w && r) begin
            exp_dout = d; exp_val = 1'b1;
        end else if (w) begin
            exp_val = 1'b0;
            if (stk.size() == DEPTH) exp_err = 1'b1; else stk.push_back(d);
        end else if (r) begin
            if (stk.size() == 0) begin exp_val = 1'b0; exp_err = 1'b1; end
            else begin exp_dout = stk.pop_back(); exp_val = 1'b1; end
        end else exp_val = 1'b0;
        #1;
        chk({tag, ".dout"}, 32'(dataout), 32'(exp_dout));
        chk({tag, ".val"}, 32'(val), 32'(exp_val));
        chk({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
`ifdef LIFO_ERR_FLAG_EN
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
`endif
    endtask

    initial begin
        exp_dout = '0; exp_val = 1'b0; exp_err = 1'b0;
        step("rst", 1, 0, 0, '0);
        chk("rst.dout0", 32'(dataout), 0);
        step("r25", 0, 1, 0, 10'h001);
        step("r25", 0, 1, 0, 10'h002);
        step("r25", 0, 1, 0, 10'h004);
        step("r25", 0, 0, 1, '0); chk("r25.pop1", 32'(dataout), 32'h004);
        step("r25", 0, 0, 1, '0); chk("r25.pop2", 32'(dataout), 32'h002);
        step("r25", 0, 0, 1, '0); chk("r25.pop3", 32'(dataout), 32'h001);
        step("r26", 0, 1, 1, 10'h16B); chk("r26.byp", 32'(dataout), 32'h16B);
        step("r26", 0, 0, 1, '0); chk("r26.empty", 32'(val), 0);
        for (int i = 0; i < DEPTH; i++) step("r27.push", 0, 1, 0, DW'(i));
        chk("r27.full", 32'(full), 1);
        step("r27.ovf", 0, 1, 0, 10'h3FF);
        step("r30", 0, 1, 1, 10'h2AA); chk("r30.byp", 32'(dataout), 32'h2AA);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step("r27.pop", 0, 0, 1, '0);
            chk("r27.order", 32'(dataout), 32'(i));
        end
        step("r28", 1, 0, 0, '0);
        step("r28", 0, 0, 1, '0); chk("r28.val", 32'(val), 0);
        for (int i = 0; i < 3; i++) step("r29.push", 0, 1, 0, DW'($urandom));
        step("r29.rst", 1, 0, 0, '0);
        step("r29.pop", 0, 0, 1, '0); chk("r29.val", 32'(val), 0);
        step("idle", 0, 0, 0, '0);
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 2 ? 75 : 25;
            step("rand", $urandom_range(99) < 2, $urandom_range(99) < bias,
                 $urandom_range(99) < 100 - bias, DW'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
